// File: rtl/cos_pkg.sv
// Shared constants, 2*pi*2^k reduction table and FSM state type for the
// cosine range-reduction front end. Fixed-point values are unsigned Q8.24.
package cos_pkg;

   localparam logic [31:0] TWO_PI  = 32'h0648_7ED5;
   localparam logic [31:0] PI      = 32'h0324_3F6B;
   localparam logic [31:0] HALF_PI = 32'h0192_1FB5;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef enum logic [3:0] {
      IDLE,
      CONVERT,
      REDUCE,
      FOLD_PI,
      FOLD_HALF,
      PACK,
      LAUNCH,
      WAIT,
      RESPOND
   } state_t;

   // 2*pi*2^k in Q8.24; k=4 (~100.5) is the largest multiple below 128.
   function automatic logic [31:0] two_pi_shl(input logic [2:0] k);
      logic [31:0] v;
      case (k)
         3'd0:    v = 32'h0648_7ED5;
         3'd1:    v = 32'h0C90_FDAA;
         3'd2:    v = 32'h1921_FB54;
         3'd3:    v = 32'h3243_F6A8;
         default: v = 32'h6487_ED50;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/cos_frontend_fixed_to_float.sv
// Combinational non-negative Q8.24 to float32 conversion with leading-one
// detect; mantissa is truncated and zero maps to +0.0.
module fixed_to_float_q8_24
   import cos_pkg::*;
(
   input  logic [31:0] q,
   output logic [31:0] f
);

   logic [4:0]  lead;
   logic [31:0] norm;

   always_comb begin
      lead = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (q[i]) lead = i[4:0];
      end
      norm = q << (5'd31 - lead);
      f    = '0;
      // Bit 0 of Q8.24 weighs 2^-24, so exponent is lead - 24 + 127.
      if (q != '0) f = {1'b0, {3'b000, lead} + 8'd103, norm[30:8]};
   end

endmodule

// File: rtl/cos_frontend.sv
// Range-reducing front end for the CORDIC cosine unit: folds a float32 angle
// into [0, pi/2], launches the cosine unit and sign-corrects its result.
module cos_frontend
   import cos_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] theta_in,
   output logic        done,
   output logic [31:0] result,
   output logic        cos_start,
   output logic [31:0] cos_theta,
   input  logic        cos_done,
   input  logic [31:0] cos_result
);

   state_t      state;
   logic [31:0] theta_r;
   logic [31:0] acc;
   logic [2:0]  k;
   logic        negate;

   logic [7:0]  exp_f;
   logic [31:0] mant_f;
   logic [31:0] conv_q;
   logic        conv_ovf;
   logic [31:0] packed_f;
   logic [31:0] step;

   // |theta| to Q8.24: mantissa weight is 2^(exp-150), Q8.24 LSB is 2^-24.
   always_comb begin
      exp_f    = theta_r[30:23];
      mant_f   = {8'h00, 1'b1, theta_r[22:0]};
      conv_q   = '0;
      conv_ovf = 1'b0;
      if (exp_f >= 8'd134)      conv_ovf = 1'b1;
      else if (exp_f >= 8'd126) conv_q = mant_f << (exp_f - 8'd126);
      else if (exp_f >= 8'd103) conv_q = mant_f >> (8'd126 - exp_f);
   end

   assign step = two_pi_shl(k);

   fixed_to_float_q8_24 u_pack (
      .q (acc),
      .f (packed_f)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         cos_start <= 1'b0;
         cos_theta <= '0;
         result    <= '0;
         negate    <= 1'b0;
         acc       <= '0;
         k         <= '0;
         theta_r   <= '0;
      end else if (!clk_en) begin
         state     <= IDLE;
         done      <= 1'b0;
         cos_start <= 1'b0;
      end else begin
         done      <= 1'b0;
         cos_start <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  theta_r <= theta_in;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               if (conv_ovf) begin
                  result <= QNAN;
                  done   <= 1'b1;
                  state  <= RESPOND;
               end else begin
                  acc   <= conv_q;
                  k     <= 3'd4;
                  state <= REDUCE;
               end
            end
            REDUCE: begin
               if (acc >= step) acc <= acc - step;
               if (k == 3'd0) state <= FOLD_PI;
               else           k     <= k - 3'd1;
            end
            FOLD_PI: begin
               if (acc > PI) acc <= TWO_PI - acc;
               state <= FOLD_HALF;
            end
            FOLD_HALF: begin
               if (acc > HALF_PI) begin
                  acc    <= PI - acc;
                  negate <= 1'b1;
               end else begin
                  negate <= 1'b0;
               end
               state <= PACK;
            end
            PACK: begin
               cos_theta <= packed_f;
               cos_start <= 1'b1;
               state     <= LAUNCH;
            end
            LAUNCH: state <= WAIT;
            WAIT: begin
               if (cos_done) begin
                  result <= {cos_result[31] ^ negate, cos_result[30:0]};
                  done   <= 1'b1;
                  state  <= RESPOND;
               end
            end
            RESPOND: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
